sr_piso: RTL and testbench
==========================

# sr_piso

Parallel-in, serial-out shift register with a load handshake. It is the transmit-side counterpart of `sr_sipo`. A WIDTH-bit word is accepted through a valid/ready handshake and shifted out LSB-first, one bit per clock. A `WIDTH`-deep `sr_sipo` clocked on the same edges therefore holds the original word once the last data bit has been sampled. Back-to-back words stream with no idle cycle between them.

## Interface
- `WIDTH`, default 4: word width in bits; legal values are ≥ 2.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `pi`  in  WIDTH: parallel word, sampled only on an accepted load.
- `load_valid`  in  1: source has a word on `pi`.
- `load_ready`  out  1: block can accept a word this cycle (combinational from state).
- `so`  out  WIDTH-independent, 1: serial data bit (registered).
- `so_valid`  out  1: `so` carries a frame bit this cycle.
- `so_last`  out  1: current bit is the final bit of the frame.
- `busy`  out  1: a frame is in progress (`so_valid` alias, kept for status use).

## Operation
- States:
  - **IDLE**: no frame in progress.
  - **SHIFT**: data bits 0..WIDTH-1 being driven.
  - **PAR**: parity bit being driven; exists only with `SR_PISO_PARITY_EN`.
- `load_ready` is 1 in IDLE, and also on the final bit cycle of a frame (`so_last`=1). It is 0 otherwise and 0 while `rst`=1.
- A word is accepted when `load_valid`&&`load_ready` at a rising edge. On that edge:
  - `so`<=`pi[0]`
  - shift register <=`pi>>1`
  - bit counter <=0
  - `so_valid`<=1
  - state <=SHIFT
- In SHIFT, each edge does the following:
  - `so`<=shreg[0], shreg<=shreg>>1 (zero fill), counter+1.
  - `so_last` is 1 when the counter equals WIDTH-1, unless parity is enabled.
- End of frame, at the edge leaving the final bit:
  - With a new accept on that edge: reload immediately, with no bubble.
  - Without an accept: return to IDLE, with `so_valid`=0, `so`=0 and `so_last`=0.
- `pi` and `load_valid` are ignored whenever `load_ready`=0. A word offered during a frame is held by the source until accepted.
- Counter width is $clog2(WIDTH). It never exceeds WIDTH-1 and wraps only via reload or IDLE.

## Timing
- Reset values: `so`=0, `so_valid`=0, `so_last`=0, `busy`=0, `load_ready`=0 during reset and 1 the cycle after. State is IDLE, shreg is 0 and the counter is 0.
- Latency: bit 0 is on `so` in the cycle immediately after the accepting edge. Bit k is on `so` k cycles later.
- Frame length is WIDTH cycles, or WIDTH+1 with parity. Sustained throughput is one frame per frame length.
- Reset mid-frame: the frame is abandoned and all outputs take reset values on the next edge. A load presented in the same cycle as `rst` is dropped.
- `load_valid` asserted in IDLE on the same edge that reset deasserts is not accepted, because `load_ready` is 0 in that cycle.

## Configuration
- `SR_PISO_PARITY_EN` defined:
  - After bit WIDTH-1, the PAR state drives one even-parity bit on `so`, with `so_valid`=1. The parity bit is the XOR of the accepted word, captured at the load edge.
  - `so_last` moves to the parity cycle.
  - `load_ready` is 1 on the parity cycle, not on bit WIDTH-1.
- Not defined: there is no PAR state, the frame is WIDTH bits, and the parity logic is absent.

## Structure
- Shared package `sr_pkg`:
  - State enum `sr_piso_state_t` (IDLE, SHIFT, PAR).
  - Width helper constant for the counter.
- One sub-module, `sr_bit_cnt`:
  - Parameterised up-counter with synchronous clear/load and a terminal-count output (`tc` at WIDTH-1).
  - Instantiated once for the bit index.
- The top level holds the FSM, the shift register, the parity register and the output registers.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `load_valid`=1 -> `so`/`so_valid`/`so_last`=0 and `load_ready`=0 throughout. `load_ready`=1 in the first cycle after release.
- Single word: WIDTH=4, `pi`=4'b1011, one accept -> `so` sequence 1,1,0,1 on the 4 following cycles, `so_last` only on the 4th. A chained `sr_sipo` then reads 4'b1011.
- Back-to-back: words 4'hA then 4'h3 with `load_valid` held -> `so`=0,1,0,1,1,1,0,0 with no gap. `load_ready` is 1 only in IDLE and on each last bit.
- Held offer: `load_valid`=1 with `pi` changing mid-frame -> serial output reflects only the word accepted at the `load_ready` edge.
- Mid-frame reset: assert `rst` after bit 1 of 4'b1011 -> all outputs 0 on the next edge, and the next accepted word 4'b0110 shifts out cleanly as 0,1,1,0.
- Parity (`SR_PISO_PARITY_EN`): `pi`=4'b1011 -> `so`=1,1,0,1,1 (5 cycles), `so_last` on the 5th. `pi`=4'b0000 -> parity bit 0.

Source files
------------

// File: rtl/sr_pkg.sv
// sr_pkg: shared state encoding and counter width helper for the shift register family
package sr_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, PAR} sr_piso_state_t;
   function automatic int cnt_w(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction
endpackage

// File: rtl/sr_bit_cnt.sv
// sr_bit_cnt: bit index up-counter with sync clear/load, saturating at terminal count WIDTH-1
module sr_bit_cnt
   import sr_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CW = cnt_w(WIDTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          ld,
   input  logic [CW-1:0] d,
   input  logic          en,
   output logic [CW-1:0] cnt,
   output logic          tc
);
   assign tc = cnt == CW'(WIDTH - 1);
   always_ff @(posedge clk) begin
      if (rst || clr) cnt <= '0;
      else if (ld) cnt <= d;
      else if (en && !tc) cnt <= cnt + CW'(1);
   end
endmodule

// File: rtl/sr_piso.sv
// sr_piso: parallel-in serial-out shifter, LSB first, valid/ready load, back-to-back frames.
// Optional even-parity trailer bit enabled by defining SR_PISO_PARITY_EN.
module sr_piso
   import sr_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pi,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             so,
   output logic             so_valid,
   output logic             so_last,
   output logic             busy
);
   localparam int CW = cnt_w(WIDTH);
   sr_piso_state_t state, state_n;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0] cnt;
   logic tc, accept, last, cnt_clr, cnt_en, so_n;
`ifdef SR_PISO_PARITY_EN
   logic par;
`endif
   sr_bit_cnt #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
      .clk(clk),
      .rst(rst),
      .clr(cnt_clr),
      .ld(1'b0),
      .d('0),
      .en(cnt_en),
      .cnt(cnt),
      .tc(tc)
   );
   always_comb begin
`ifdef SR_PISO_PARITY_EN
      last = state == PAR;
`else
      last = state == SHIFT && tc;
`endif
      load_ready = !rst && (state == IDLE || last);
      accept = load_valid && load_ready;
      state_n = accept ? SHIFT : last ? IDLE : (state == SHIFT && tc) ? PAR : state;
      cnt_clr = accept || state_n == IDLE;
      cnt_en = state == SHIFT;
      so_valid = state != IDLE;
      busy = so_valid;
      so_last = last;
   end
   // value driven on so after this edge when neither loading nor shifting a data bit
`ifdef SR_PISO_PARITY_EN
   assign so_n = (state_n == PAR) ? par : 1'b0;
`else
   assign so_n = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= state_n;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         so <= 1'b0;
         shreg <= '0;
      end else if (accept) begin
         so <= pi[0];
         shreg <= pi >> 1;
      end else if (state == SHIFT && !tc) begin
         so <= shreg[0];
         shreg <= shreg >> 1;
      end else begin
         so <= so_n;
      end
   end
`ifdef SR_PISO_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) par <= 1'b0;
      else if (accept) par <= ^pi;
   end
`endif
endmodule

// File: tb/tb_sr_piso.sv
// tb_sr_piso: random and directed stimulus checked every cycle against a frame-queue model
module tb_sr_piso;
   localparam int W = 4;
`ifdef SR_PISO_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int FL = W + P;
   logic clk = 1'b0, rst = 1'b1, load_valid = 1'b0;
   logic [W-1:0] pi = '0;
   logic load_ready, so, so_valid, so_last, busy;
   int checks = 0, failures = 0;
   bit m_act = 1'b0;
   int m_pos = 0;
   logic [FL-1:0] m_frame = '0;
   logic cap[$];

   sr_piso #(.WIDTH(W)) dut (
      .clk(clk),
      .rst(rst),
      .pi(pi),
      .load_valid(load_valid),
      .load_ready(load_ready),
      .so(so),
      .so_valid(so_valid),
      .so_last(so_last),
      .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic m_ready();
      return !rst && (!m_act || m_pos == FL - 1);
   endfunction

   function automatic logic [FL-1:0] frame_of(input logic [W-1:0] d);
      logic [FL-1:0] f;
      f = '0;
      f[W-1:0] = d;
      if (P == 1) f[FL-1] = ^d;
      return f;
   endfunction

   function automatic int cap_val();
      int v;
      v = 0;
      foreach (cap[i]) if (cap[i]) v |= (1 << i);
      return v;
   endfunction

   task automatic chk(input string n, input logic a, input logic e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s got=%0b exp=%0b t=%0t", n, a, e, $time);
      end
   endtask

   task automatic lit(input string n, input int a, input int e);
      checks++;
      if (a != e) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", n, a, e, $time);
      end
   endtask

   task automatic cycle(input logic r, input logic v, input logic [W-1:0] d);
      @(negedge clk);
      rst = r;
      load_valid = v;
      pi = d;
      #1;
      chk("so_valid", so_valid, m_act);
      chk("busy", busy, m_act);
      chk("so", so, m_act ? m_frame[m_pos] : 1'b0);
      chk("so_last", so_last, m_act && m_pos == FL - 1);
      chk("load_ready", load_ready, m_ready());
      if (so_valid === 1'b1) cap.push_back(so);
      @(posedge clk);
      if (r) begin
         m_act = 1'b0;
         m_pos = 0;
      end else if (v && m_ready()) begin
         m_frame = frame_of(d);
         m_pos = 0;
         m_act = 1'b1;
      end else if (m_act) begin
         m_pos++;
         if (m_pos == FL) begin
            m_act = 1'b0;
            m_pos = 0;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, W'($urandom));
   endtask

   initial begin
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, W'($urandom));
      idle(2);
      cap.delete();
      cycle(1'b0, 1'b1, 4'b1011);
      idle(FL + 1);
      lit("single_val", cap_val(), 11 | (P << 4));
      lit("single_len", cap.size(), FL);
      cap.delete();
      cycle(1'b0, 1'b1, 4'hA);
      for (int i = 0; i < FL; i++) cycle(1'b0, 1'b1, 4'h3);
      idle(FL + 1);
      lit("b2b_val", cap_val(), (P == 1) ? 32'h6A : 32'h3A);
      lit("b2b_len", cap.size(), 2 * FL);
      cap.delete();
      cycle(1'b0, 1'b1, 4'b1011);
      cycle(1'b0, 1'b0, 4'b1111);
      cycle(1'b1, 1'b1, 4'b1111);
      idle(2);
      lit("abort_val", cap_val(), 3);
      lit("abort_len", cap.size(), 2);
      cap.delete();
      cycle(1'b0, 1'b1, 4'b0110);
      idle(FL + 1);
      lit("after_rst_val", cap_val(), 6);
      lit("after_rst_len", cap.size(), FL);
      cap.delete();
      cycle(1'b0, 1'b1, 4'b0000);
      idle(FL + 1);
      lit("zero_val", cap_val(), 0);
      lit("zero_len", cap.size(), FL);
      for (int i = 0; i < 3000; i++)
         cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 7), W'($urandom));
      idle(FL + 2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
